ifft_serial: RTL and testbench
==============================

// Module: ifft_serial
// PURPOSE
//  Sequential radix-2 DIT inverse FFT. Receives the complex spectrum the FFT produces.
//  Input is one sample per cycle over a valid/ready stream. Samples are stored bit-reversed.
//  The block runs log2(Bus) butterfly stages in place, one butterfly per cycle.
//  It then streams Bus time-domain samples out over valid/ready.
//  Result is scaled by 1/Bus (each stage >>1), so IFFT(FFT(x)) returns x within a few LSBs.
// PARAMETERS
//  Bus        8   transform length; power of 2, 4..64
//  Bit_depth  12  width of each real and imaginary part, two's complement
//  TW_W       16  twiddle width, signed Q1.14 (+1.0 = 16384)
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous active-low reset
//  in_data    in   2*Bit_depth  complex spectrum sample {im, re}
//  in_valid   in   1            in_data valid
//  in_ready   out  1            block accepts in_data this cycle
//  out_data   out  2*Bit_depth  complex time sample {im, re}, natural order n=0..Bus-1
//  out_valid  out  1            out_data valid
//  out_ready  in   1            sink accepts out_data
//  out_last   out  1            high with sample n=Bus-1
//  busy       out  1            high in CALC or DRAIN
// BEHAVIOUR
//  Reset:
//   - state=LOAD; all counters 0; in_ready=1; out_valid=0; out_last=0; busy=0; out_data=0.
//   - Buffer contents are don't-care.
//  States:
//   - LOAD: in_ready=1. A transfer happens when in_valid&in_ready.
//     Sample k is written to buf[bitrev(k)]. After the Bus-th transfer, go to CALC.
//   - CALC: in_ready=0. s=0..log2(Bus)-1, b=0..Bus/2-1, one butterfly per cycle.
//     Address calculation:
//       half = 1<<s; pos = b&(half-1)
//       ia = ((b>>s)<<(s+1)) + pos; ib = ia + half; tw index = pos<<(log2(Bus)-1-s)
//     Reads of buf[ia] and buf[ib] are combinational. Both results are written at the clock edge.
//     After the last butterfly, go to DRAIN.
//     Duration is exactly (Bus/2)*log2(Bus) cycles (Bus=8: 12 cycles).
//   - DRAIN: out_data = buf[n]; out_valid=1.
//     n advances only when out_valid&out_ready.
//     out_last is high when n=Bus-1. After that transfer: go to LOAD, out_valid=0, in_ready=1.
//  Handshakes:
//   - in_valid while in_ready=0 is ignored; no sample is lost from the source side.
//   - out_ready low holds out_data and out_valid stable.
//   - No overlap between frames: the first LOAD transfer is no earlier than the cycle after the last DRAIN transfer.
//  Butterfly, with w = e^{+j*2*pi*k/Bus} (conjugate twiddle):
//   - p = w*B: four Bit_depth x TW_W signed products. Real = rr-ii, imag = ri+ir.
//     Each part is rounded half-up by adding 1<<13 then arithmetic >>14.
//     Keep Bit_depth+2 bits.
//   - A' = (A+p+1)>>>1; B' = (A-p+1)>>>1, computed per part at Bit_depth+2 bits.
//   - Each part is then saturated to [-2^(Bit_depth-1), 2^(Bit_depth-1)-1].
//  Latency: last input transfer to first out_valid = (Bus/2)*log2(Bus)+1 cycles.
//  Reset mid-operation (any state): immediate return to reset values. Partial frame is discarded.
// STRUCTURE
//  Package fft_pkg:
//   - 64-entry Q1.14 cos/sin table for angles 2*pi*k/64.
//   - State enum {LOAD, CALC, DRAIN}.
//   - bitrev function.
//  Sub-module ifft_twiddle_rom (Bus, TW_W): combinational.
//   - Index k returns {sin, cos} = table[k*64/Bus]; sin positive (inverse direction).
//  Top holds the FSM, counters, Bus x 2*Bit_depth register buffer and one butterfly datapath.
// TESTING  (Bus=8, Bit_depth=12; all values {re,im})
//  1 X[0]=(800,0), others 0 -> all 8 outputs (100,0); out_last only on 8th.
//  2 All X[k]=(800,0) -> x[0]=(800,0), x[1..7]=(0,0) exactly.
//  3 X[1]=(800,0) -> x[0]=(100,0), x[1]=(71,71)+-1, x[2]=(0,100), x[4]=(-100,0).
//  4 Case 3 with out_ready toggling 1010... -> same 8 values, none dropped or repeated.
//    in_valid held high during CALC is ignored.
//  5 rst_n pulsed low at CALC cycle 5 -> outputs return to reset values asynchronously.
//    The next full frame (case 1) gives correct results.
//  6 All X[k]=(-2048,-2048) -> x[0]=(-2048,-2048), others (0,0); no wrap.
//    Also check CALC = 12 cycles.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the serial inverse FFT.
// Holds the state enum, a Q1.14 sine/cosine table and bit reversal.
package fft_pkg;

    typedef enum logic [1:0] {LOAD, CALC, DRAIN} state_t;

    localparam int TBL_N = 64;
    localparam int TBL_W = 16;

    // Quarter wave of sin(2*pi*k/64), Q1.14; the 64-entry table is
    // folded out of these 17 points by symmetry.
    localparam logic signed [TBL_W-1:0] QSIN [17] = '{
        16'sd0,     16'sd1606,  16'sd3196,  16'sd4756,
        16'sd6270,  16'sd7723,  16'sd9102,  16'sd10394,
        16'sd11585, 16'sd12665, 16'sd13623, 16'sd14449,
        16'sd15137, 16'sd15678, 16'sd16069, 16'sd16305,
        16'sd16384
    };

    function automatic logic signed [TBL_W-1:0] tbl_sin(
        input logic [5:0] k
    );
        int ki;
        ki = int'(k);
        if (ki <= 16)      return QSIN[ki];
        else if (ki <= 32) return QSIN[32-ki];
        else if (ki <= 48) return -QSIN[ki-32];
        else               return -QSIN[64-ki];
    endfunction

    function automatic logic signed [TBL_W-1:0] tbl_cos(
        input logic [5:0] k
    );
        return tbl_sin(k + 6'd16);
    endfunction

    // Reverse the low 'bits' bits of v.
    function automatic logic [5:0] bitrev(
        input logic [5:0] v,
        input int         bits
    );
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            if (i < bits) r[bits-1-i] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ifft_twiddle_rom.sv
// Combinational twiddle lookup for the inverse FFT: idx -> {sin, cos}
// of +2*pi*idx/Bus. Ports: idx (twiddle index), tw ({sin, cos}, Q1.14).
module ifft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int Bus  = 8,
    parameter int TW_W = 16
) (
    input  logic [$clog2(Bus)-1:0] idx,
    output logic [2*TW_W-1:0]      tw
);

    localparam int L = $clog2(Bus);

    logic [5:0]             k;
    logic signed [TW_W-1:0] w_cos;
    logic signed [TW_W-1:0] w_sin;

    // Scale the index onto the 64-point table.
    assign k     = 6'(idx) << (6 - L);
    assign w_cos = TW_W'(tbl_cos(k));
    assign w_sin = TW_W'(tbl_sin(k));
    assign tw    = {w_sin, w_cos};

endmodule

// File: rtl/ifft_serial.sv
// Serial in-place radix-2 DIT inverse FFT, one butterfly per cycle.
// Ports: clk, rst_n, in_* (spectrum stream), out_* (time stream), busy.
module ifft_serial
    import fft_pkg::*;
#(
    parameter int Bus       = 8,
    parameter int Bit_depth = 12,
    parameter int TW_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2*Bit_depth-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [2*Bit_depth-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy
);

    localparam int L    = $clog2(Bus);
    localparam int BD   = Bit_depth;
    localparam int DW   = 2 * BD;
    localparam int EW   = BD + 2;
    localparam int PW   = BD + TW_W + 1;
    localparam int FRAC = TW_W - 2;

    localparam logic signed [PW-1:0] RND  = PW'(1 << (FRAC - 1));
    localparam logic signed [EW-1:0] ONE  = EW'(1);
    localparam logic signed [EW-1:0] SMAX = EW'((1 << (BD - 1)) - 1);
    localparam logic signed [EW-1:0] SMIN = EW'(-(1 << (BD - 1)));

    state_t state, state_nx;

    logic [L-1:0]  idx;
    logic [L-1:0]  stg;
    logic [L-2:0]  bfly;
    logic          last_bfly;
    logic [DW-1:0] mem [Bus];

    logic [L-1:0] b_ext, half, pos, ia, ib, tw_idx, wr_addr;

    assign b_ext  = {1'b0, bfly};
    assign half   = L'(1) << stg;
    assign pos    = b_ext & (half - L'(1));
    assign ia     = ((b_ext >> stg) << (stg + L'(1))) + pos;
    assign ib     = ia + half;
    assign tw_idx = pos << (L'(L - 1) - stg);

    assign wr_addr   = L'(bitrev(6'(idx), L));
    assign last_bfly = (stg == L'(L - 1)) && (&bfly);

    logic [2*TW_W-1:0]      tw;
    logic signed [TW_W-1:0] w_c, w_s;

    ifft_twiddle_rom #(
        .Bus  (Bus),
        .TW_W (TW_W)
    ) u_rom (
        .idx (tw_idx),
        .tw  (tw)
    );

    assign w_c = tw[TW_W-1:0];
    assign w_s = tw[2*TW_W-1:TW_W];

    logic signed [BD-1:0] a_re, a_im, b_re, b_im;

    assign a_re = mem[ia][BD-1:0];
    assign a_im = mem[ia][DW-1:BD];
    assign b_re = mem[ib][BD-1:0];
    assign b_im = mem[ib][DW-1:BD];

    logic signed [PW-1:0] rr, ii, ri, ir, p_re_w, p_im_w;
    logic signed [EW-1:0] p_re, p_im;

    assign rr = PW'(b_re) * PW'(w_c);
    assign ii = PW'(b_im) * PW'(w_s);
    assign ri = PW'(b_re) * PW'(w_s);
    assign ir = PW'(b_im) * PW'(w_c);

    // Round half-up back to integer scale.
    assign p_re_w = rr - ii + RND;
    assign p_im_w = ri + ir + RND;
    assign p_re   = EW'(p_re_w >>> FRAC);
    assign p_im   = EW'(p_im_w >>> FRAC);

    logic signed [EW-1:0] s_ar, s_ai, s_br, s_bi;

    assign s_ar = EW'(a_re) + p_re + ONE;
    assign s_ai = EW'(a_im) + p_im + ONE;
    assign s_br = EW'(a_re) - p_re + ONE;
    assign s_bi = EW'(a_im) - p_im + ONE;

    function automatic logic [BD-1:0] sat(
        input logic signed [EW-1:0] v
    );
        if (v > SMAX)      return SMAX[BD-1:0];
        else if (v < SMIN) return SMIN[BD-1:0];
        else               return v[BD-1:0];
    endfunction

    logic [DW-1:0] a_new, b_new;

    assign a_new = {sat(s_ai >>> 1), sat(s_ar >>> 1)};
    assign b_new = {sat(s_bi >>> 1), sat(s_br >>> 1)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
            idx   <= '0;
            stg   <= '0;
            bfly  <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                LOAD: begin
                    if (in_valid) idx <= idx + L'(1);
                end
                CALC: begin
                    bfly <= bfly + (L-1)'(1);
                    if (&bfly) begin
                        stg <= (stg == L'(L - 1)) ? '0 : stg + L'(1);
                    end
                end
                DRAIN: begin
                    if (out_ready) idx <= idx + L'(1);
                end
                default: ;
            endcase
        end
    end

    // Sample buffer carries no reset; its contents are rewritten every frame.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid) begin
            mem[wr_addr] <= in_data;
        end else if (state == CALC) begin
            mem[ia] <= a_new;
            mem[ib] <= b_new;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        out_data  = '0;
        unique case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && idx == L'(Bus - 1)) state_nx = CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (last_bfly) state_nx = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = mem[idx];
                out_last  = (idx == L'(Bus - 1));
                if (out_ready && out_last) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

endmodule

// File: tb/tb_ifft_serial.sv
// Self-checking bench for ifft_serial (Bus=8, Bit_depth=12).
// Expected samples go to a scoreboard queue when a frame is sent.
module tb_ifft_serial;

    logic        clk;
    logic        rst_n;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int re;
        int im;
        int tol;
        bit last;
    } exp_t;

    exp_t sb[$];

    int fr_re[8];
    int fr_im[8];

    ifft_serial #(
        .Bus       (8),
        .Bit_depth (12),
        .TW_W      (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input int n, input int re, input int im,
                            input int tol);
        exp_t e;
        e.re   = re;
        e.im   = im;
        e.tol  = tol;
        e.last = (n == 7);
        sb.push_back(e);
    endtask

    task automatic set_frame(input int re0, input int im0,
                             input int rer, input int imr);
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = (k == 0) ? re0 : rer;
            fr_im[k] = (k == 0) ? im0 : imr;
        end
    endtask

    task automatic send_frame();
        for (int k = 0; k < 8; k++) begin
            int w;
            @(negedge clk);
            in_data  = {12'(fr_im[k]), 12'(fr_re[k])};
            in_valid = 1'b1;
            w = 0;
            while (!in_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (!in_ready) begin
                errors++;
                $display("FAIL send_ready k=%0d: in_ready=%b, want 1",
                         k, in_ready);
            end
        end
    endtask

    // Counts CALC cycles up to the first out_valid; optionally keeps
    // in_valid asserted with junk data while the block is busy.
    task automatic wait_calc(input bit hold, output int calc);
        int cyc;
        int rdy_bad;
        calc    = 0;
        cyc     = 0;
        rdy_bad = 0;
        @(negedge clk);
        in_valid = hold;
        in_data  = 24'h5A35A3;
        while (!out_valid && cyc < 200) begin
            if (busy) calc++;
            if (in_ready) rdy_bad++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL calc_timeout: out_valid=%b, want 1", out_valid);
        end
        checks++;
        if (calc != 12) begin
            errors++;
            $display("FAIL calc_cycles: got %0d, want 12", calc);
        end
        checks++;
        if (rdy_bad != 0) begin
            errors++;
            $display("FAIL calc_in_ready: high %0d cycles, want 0", rdy_bad);
        end
    endtask

    task automatic drain(input bit toggle);
        int          n;
        int          cyc;
        bit          ph;
        bit          stalled;
        logic [23:0] held;
        n       = 0;
        cyc     = 0;
        ph      = 1'b1;
        stalled = 1'b0;
        while (n < 8 && cyc < 400) begin
            if (cyc != 0) @(negedge clk);
            cyc++;
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    errors++;
                    $display("FAIL hold: valid=%b data=%h, want 1 %h",
                             out_valid, out_data, held);
                end
                stalled = 1'b0;
            end
            out_ready = toggle ? ph : 1'b1;
            ph = ~ph;
            #1;
            if (out_valid) begin
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_out n=%0d: data=%h, want none",
                                 n, out_data);
                    end else begin
                        exp_t e;
                        int   ar, ai, dr, di;
                        e  = sb.pop_front();
                        ar = $signed(out_data[11:0]);
                        ai = $signed(out_data[23:12]);
                        dr = (ar > e.re) ? ar - e.re : e.re - ar;
                        di = (ai > e.im) ? ai - e.im : e.im - ai;
                        checks++;
                        if (dr > e.tol || di > e.tol) begin
                            errors++;
                            $display("FAIL data n=%0d: got (%0d,%0d), want (%0d,%0d)+-%0d",
                                     n, ar, ai, e.re, e.im, e.tol);
                        end
                        checks++;
                        if (out_last !== e.last) begin
                            errors++;
                            $display("FAIL last n=%0d: got %b, want %b",
                                     n, out_last, e.last);
                        end
                    end
                    n++;
                end else begin
                    held    = out_data;
                    stalled = 1'b1;
                end
            end
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL drain_timeout: got %0d samples, want 8", n);
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_end: valid=%b ready=%b busy=%b, want 0 1 0",
                     out_valid, in_ready, busy);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_left: %0d entries, want 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            busy !== 1'b0 || out_data !== 24'h0) begin
            errors++;
            $display("FAIL %s: rdy=%b val=%b last=%b busy=%b data=%h, want 1 0 0 0 0",
                     tag, in_ready, out_valid, out_last, busy, out_data);
        end
    endtask

    task automatic run_impulse(input bit toggle);
        int calc;
        set_frame(800, 0, 0, 0);
        for (int n = 0; n < 8; n++) push_exp(n, 100, 0, 0);
        send_frame();
        wait_calc(1'b0, calc);
        drain(toggle);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_low");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset_release");
    endtask

    task automatic test_impulse();
        run_impulse(1'b0);
    endtask

    task automatic test_dc();
        int calc;
        set_frame(800, 0, 800, 0);
        push_exp(0, 800, 0, 0);
        for (int n = 1; n < 8; n++) push_exp(n, 0, 0, 0);
        send_frame();
        wait_calc(1'b0, calc);
        drain(1'b0);
    endtask

    task automatic tone(input bit toggle);
        int calc;
        int cre[8];
        int cim[8];
        cre = '{100, 71, 0, -71, -100, -71, 0, 71};
        cim = '{0, 71, 100, 71, 0, -71, -100, -71};
        set_frame(0, 0, 0, 0);
        fr_re[1] = 800;
        for (int n = 0; n < 8; n++) push_exp(n, cre[n], cim[n], 1);
        send_frame();
        wait_calc(toggle, calc);
        drain(toggle);
    endtask

    task automatic test_tone();
        tone(1'b0);
    endtask

    task automatic test_back_to_back();
        tone(1'b1);
    endtask

    task automatic test_reset_mid();
        int cyc;
        set_frame(800, 0, 0, 0);
        send_frame();
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_calc: busy=%b valid=%b, want 1 0",
                     busy, out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset_after");
        run_impulse(1'b0);
    endtask

    task automatic test_neg_full();
        int calc;
        set_frame(-2048, -2048, -2048, -2048);
        push_exp(0, -2048, -2048, 0);
        for (int n = 1; n < 8; n++) push_exp(n, 0, 0, 0);
        send_frame();
        wait_calc(1'b0, calc);
        drain(1'b0);
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_dc();
        test_tone();
        test_back_to_back();
        test_reset_mid();
        test_neg_full();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
